conv_param_loader: RTL

CONV_PARAM_LOADER -- requirements
Module: conv_param_loader

---
 rtl/conv_param_loader_if.sv | 47 ++++
 rtl/conv_param_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/conv_param_loader_if.sv
// Handshake and write-port bundle for the convolution parameter loader.
// The master drives starts, config and the parameter stream; the slave is the loader.
interface conv_param_loader_if #(
  parameter int BIAS_GROUP_BITS = 7,
  parameter int WT_BITS         = 72
);
  logic                       start_bias;
  logic                       start_wt;
  logic [BIAS_GROUP_BITS-1:0] cfg_og_first;
  logic [BIAS_GROUP_BITS:0]   cfg_og_count;
  logic [9:0]                 cfg_ci_groups;

  logic [127:0]               s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_last;

  logic                       bias_wr_en;
  logic [127:0]               bias_wr_data;
  logic                       bias_wr_addr_rst;

  logic                       wt_wr_en;
  logic [WT_BITS-1:0]         wt_wr_data;
  logic                       wt_wr_addr_rst;

  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start_bias, start_wt, cfg_og_first, cfg_og_count, cfg_ci_groups,
    output s_data, s_valid, s_last,
    input  s_ready,
    input  bias_wr_en, bias_wr_data, bias_wr_addr_rst,
    input  wt_wr_en, wt_wr_data, wt_wr_addr_rst,
    input  busy, done, err
  );

  modport slave (
    input  start_bias, start_wt, cfg_og_first, cfg_og_count, cfg_ci_groups,
    input  s_data, s_valid, s_last,
    output s_ready,
    output bias_wr_en, bias_wr_data, bias_wr_addr_rst,
    output wt_wr_en, wt_wr_data, wt_wr_addr_rst,
    output busy, done, err
  );
endinterface

// File: rtl/conv_param_loader.sv
// Convolution parameter loader: moves a bias batch or one output group of
// 3x3 weights from a 128-bit stream into the bias/weight buffer write ports.
//
// state    | meaning
// IDLE     | waiting for start_bias / start_wt
// B_RST    | one-cycle bias buffer address reset (batch starts at OG0)
// B_STREAM | accepting bias beats, 4 x 32-bit biases per beat
// W_RST    | one-cycle weight buffer address reset
// W_STREAM | accepting weight beats, low WT_BITS of each beat used
// FIN      | one-cycle done pulse, then back to IDLE
module conv_param_loader #(
  parameter int BIAS_GROUP_BITS = 7,
  parameter int WT_BITS         = 72
) (
  input logic               clk,
  input logic               rst_n,
  conv_param_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    B_RST    = 3'd1,
    B_STREAM = 3'd2,
    W_RST    = 3'd3,
    W_STREAM = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t               state_q;
  logic [31:0]          remain_q;
  logic                 s_ready_q;
  logic                 bias_wr_en_q;
  logic [127:0]         bias_wr_data_q;
  logic                 bias_addr_rst_q;
  logic                 wt_wr_en_q;
  logic [WT_BITS-1:0]   wt_wr_data_q;
  logic                 wt_addr_rst_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [31:0]          bias_beats_d;
  logic [31:0]          wt_beats_d;
  logic                 xfer_d;
  logic                 last_beat_d;

  // Load sizes from the live config (latched into remain_q on accept) and beat qualifiers.
  always_comb begin
    bias_beats_d = 32'(bus.cfg_og_count) << 1;
    wt_beats_d   = 32'(bus.cfg_ci_groups) << 6;
    xfer_d       = bus.s_valid & s_ready_q;
    last_beat_d  = (remain_q == 32'd1);
  end

  // Sequencer with registered outputs; write strobes, addr resets and done default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      remain_q        <= '0;
      s_ready_q       <= 1'b0;
      bias_wr_en_q    <= 1'b0;
      bias_wr_data_q  <= '0;
      bias_addr_rst_q <= 1'b0;
      wt_wr_en_q      <= 1'b0;
      wt_wr_data_q    <= '0;
      wt_addr_rst_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      bias_wr_en_q    <= 1'b0;
      wt_wr_en_q      <= 1'b0;
      bias_addr_rst_q <= 1'b0;
      wt_addr_rst_q   <= 1'b0;
      done_q          <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // start_bias has priority; a simultaneous start_wt is dropped.
          if (bus.start_bias) begin
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            remain_q <= bias_beats_d;
            if (bus.cfg_og_first == '0) begin
              state_q         <= B_RST;
              bias_addr_rst_q <= 1'b1;
            end else if (bias_beats_d == 32'd0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= B_STREAM;
              s_ready_q <= 1'b1;
            end
          end else if (bus.start_wt) begin
            err_q         <= 1'b0;
            busy_q        <= 1'b1;
            remain_q      <= wt_beats_d;
            state_q       <= W_RST;
            wt_addr_rst_q <= 1'b1;
          end
        end
        B_RST, W_RST: begin
          if (remain_q == 32'd0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q   <= (state_q == B_RST) ? B_STREAM : W_STREAM;
            s_ready_q <= 1'b1;
          end
        end
        B_STREAM, W_STREAM: begin
          if (xfer_d) begin
            if (state_q == B_STREAM) begin
              bias_wr_en_q   <= 1'b1;
              bias_wr_data_q <= bus.s_data;
            end else begin
              wt_wr_en_q   <= 1'b1;
              wt_wr_data_q <= bus.s_data[WT_BITS-1:0];
            end
            // s_last must coincide with the final expected beat; the load runs to count anyway.
            if (bus.s_last != last_beat_d) err_q <= 1'b1;
            remain_q <= remain_q - 32'd1;
            if (last_beat_d) s_ready_q <= 1'b0;
          end else if (remain_q == 32'd0) begin
            // Final write is on the port this cycle, so done lands one cycle after it.
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready          = s_ready_q;
  assign bus.bias_wr_en       = bias_wr_en_q;
  assign bus.bias_wr_data     = bias_wr_data_q;
  assign bus.bias_wr_addr_rst = bias_addr_rst_q;
  assign bus.wt_wr_en         = wt_wr_en_q;
  assign bus.wt_wr_data       = wt_wr_data_q;
  assign bus.wt_wr_addr_rst   = wt_addr_rst_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;

endmodule
